// File: rtl/mdr_write_serializer_pkg.sv
// Shared CPU constants for the memory data register: store formats and
// serializer state encoding, used by both the read and write sides.
package mdr_write_serializer_pkg;

  typedef enum logic [1:0] {
    FMT_BYTE  = 2'b00,
    FMT_WORD  = 2'b01,
    FMT_INSTR = 2'b10,
    FMT_RSVD  = 2'b11
  } fmt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdr_byte_select.sv
// Picks byte number i_idx of a store image and flags whether it is the
// final byte of that format.
module mdr_byte_select
  import mdr_write_serializer_pkg::*;
(
  input  logic [1:0]  i_fmt,
  input  logic [1:0]  i_idx,
  input  logic [14:0] i_data,
  input  logic [3:0]  i_op,
  output logic [7:0]  o_byte,
  output logic        o_last
);

  always_comb begin
    o_byte = 8'h00;
    o_last = 1'b1;
    case (i_fmt)
      FMT_BYTE: begin
        o_byte = i_data[7:0];
        o_last = 1'b1;
      end
      FMT_WORD: begin
        o_byte = (i_idx == 2'd0) ? i_data[7:0] : {1'b0, i_data[14:8]};
        o_last = (i_idx == 2'd1);
      end
      FMT_INSTR: begin
        case (i_idx)
          2'd0:    o_byte = {4'b0000, i_op};
          2'd1:    o_byte = i_data[7:0];
          default: o_byte = {1'b0, i_data[14:8]};
        endcase
        o_last = (i_idx == 2'd2);
      end
      default: begin
        o_byte = 8'h00;
        o_last = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mdr_write_serializer.sv
// Write-side memory data register: latches a byte/word/instruction and
// streams it low byte first to byte-wide memory with incrementing addresses.
module mdr_write_serializer
  import mdr_write_serializer_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        fmt,
  input  logic [14:0]       data_in,
  input  logic [3:0]        op_in,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            r_state;
  logic [1:0]        r_fmt;
  logic [1:0]        r_idx;
  logic [14:0]       r_data;
  logic [3:0]        r_op;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              r_last;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  state_t            w_state_nxt;
  logic              w_load;
  logic              w_adv;
  logic [1:0]        w_sel_fmt;
  logic [1:0]        w_sel_idx;
  logic [14:0]       w_sel_data;
  logic [3:0]        w_sel_op;
  logic [7:0]        w_byte;
  logic              w_last;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [7:0]        w_data_nxt;
  logic              w_last_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;

  // Outputs are registered, so the selector always looks one byte ahead:
  // the first byte straight from the inputs, later bytes from the latch.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_sel_fmt  = fmt;
      w_sel_idx  = 2'd0;
      w_sel_data = data_in;
      w_sel_op   = op_in;
    end else begin
      w_sel_fmt  = r_fmt;
      w_sel_idx  = r_idx + 2'd1;
      w_sel_data = r_data;
      w_sel_op   = r_op;
    end
  end

  mdr_byte_select u_sel (
    .i_fmt  (w_sel_fmt),
    .i_idx  (w_sel_idx),
    .i_data (w_sel_data),
    .i_op   (w_sel_op),
    .o_byte (w_byte),
    .o_last (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_we_nxt    = r_mem_we;
    w_addr_nxt  = r_mem_addr;
    w_data_nxt  = r_mem_data;
    w_last_nxt  = r_last;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (fmt == FMT_RSVD) begin
            w_err_nxt = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_SEND;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = base_addr;
            w_data_nxt  = w_byte;
            w_last_nxt  = w_last;
          end
        end
      end
      ST_SEND: begin
        if (mem_ready) begin
          if (r_last) begin
            w_state_nxt = ST_DONE;
            w_we_nxt    = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_adv      = 1'b1;
            w_addr_nxt = r_mem_addr + ADDR_W'(1);
            w_data_nxt = w_byte;
            w_last_nxt = w_last;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: begin
        w_state_nxt = ST_IDLE;
        w_we_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fmt      <= 2'b00;
      r_idx      <= 2'd0;
      r_data     <= '0;
      r_op       <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_we   <= w_we_nxt;
      r_mem_addr <= w_addr_nxt;
      r_mem_data <= w_data_nxt;
      r_last     <= w_last_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      if (w_load) begin
        r_fmt  <= fmt;
        r_data <= data_in;
        r_op   <= op_in;
        r_idx  <= 2'd0;
      end else if (w_adv) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_mdr_write_serializer.sv
// Scoreboard bench for mdr_write_serializer: expected byte writes are queued
// at stimulus time and checked as memory accepts them.
module tb_mdr_write_serializer;
  import mdr_write_serializer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  fmt;
  logic [14:0] data_in;
  logic [3:0]  op_in;
  logic [7:0]  base_addr;
  logic        mem_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;
  int nwr   = 0;
  logic [15:0] expq[$];

  mdr_write_serializer #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fmt       (fmt),
    .data_in   (data_in),
    .op_in     (op_in),
    .base_addr (base_addr),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] f);
    case (f)
      FMT_BYTE:  return 1;
      FMT_WORD:  return 2;
      FMT_INSTR: return 3;
      default:   return 0;
    endcase
  endfunction

  task automatic push_exp(input logic [1:0] f, input logic [14:0] d, input logic [3:0] op,
                          input logic [7:0] base);
    logic [7:0] a1, a2;
    a1 = base + 8'd1;
    a2 = base + 8'd2;
    case (f)
      FMT_BYTE: expq.push_back({base, d[7:0]});
      FMT_WORD: begin
        expq.push_back({base, d[7:0]});
        expq.push_back({a1, 1'b0, d[14:8]});
      end
      FMT_INSTR: begin
        expq.push_back({base, 4'h0, op});
        expq.push_back({a1, d[7:0]});
        expq.push_back({a2, 1'b0, d[14:8]});
      end
      default: ;
    endcase
  endtask

  // Every accepted byte must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && mem_we && mem_ready) begin
      logic [15:0] e;
      nwr++;
      chk("wr_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("wr_addr", mem_addr, e[15:8]);
        chk("wr_data", mem_data, e[7:0]);
      end
    end
  end

  task automatic run(input logic [1:0] f, input logic [14:0] d, input logic [3:0] op,
                     input logic [7:0] base, input int exp_done, input int stall,
                     input bit restart, input int exp_busy);
    int got = 0;
    int nb  = 0;
    int w0  = nwr;
    logic [15:0] first;
    push_exp(f, d, op, base);
    first = expq[0];
    @(posedge clk); #1;
    start = 1'b1; fmt = f; data_in = d; op_in = op; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0; data_in = ~d; op_in = ~op; base_addr = ~base;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        got = k;
        break;
      end
      if (k <= stall) begin
        chk("stall_we", mem_we, 1);
        chk("stall_addr", mem_addr, first[15:8]);
        chk("stall_data", mem_data, first[7:0]);
        if (k == stall) begin
          @(posedge clk); #1;
          mem_ready = 1'b1;
        end
      end
      if (restart && k == 1) begin
        start = 1'b1; fmt = FMT_BYTE; data_in = 15'h7E7E; base_addr = 8'hC0;
      end
      if (restart && k == 2) start = 1'b0;
    end
    chk("done_lat", got, exp_done);
    chk("busy_cyc", nb, exp_busy);
    chk("n_writes", nwr - w0, nbytes(f));
    chk("q_empty", expq.size(), 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int w0;
    rst = 1'b1; start = 1'b0; fmt = FMT_BYTE; data_in = '0; op_in = '0;
    base_addr = '0; mem_ready = 1'b1;
    #12;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run(FMT_WORD, 15'h5A3C, 4'h0, 8'h10, 3, 0, 0, 3);
    run(FMT_INSTR, 15'h1234, 4'hB, 8'h20, 4, 0, 0, 4);
    mem_ready = 1'b0;
    run(FMT_BYTE, 15'h00A5, 4'h0, 8'h40, 5, 3, 0, 5);
    run(FMT_WORD, 15'h6B21, 4'h0, 8'hFF, 3, 0, 0, 3);

    // reserved format: error pulse only
    w0 = nwr;
    @(posedge clk); #1;
    start = 1'b1; fmt = FMT_RSVD; data_in = 15'h1111; base_addr = 8'h50;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("rsvd_err", err, 1);
    chk("rsvd_busy", busy, 0);
    chk("rsvd_we", mem_we, 0);
    @(negedge clk);
    chk("rsvd_err_clr", err, 0);
    chk("rsvd_busy2", busy, 0);
    chk("rsvd_nwr", nwr - w0, 0);

    run(FMT_INSTR, 15'h3C5A, 4'h6, 8'h60, 4, 0, 1, 4);

    // reset after the first INSTR byte is accepted
    w0 = nwr;
    push_exp(FMT_INSTR, 15'h2468, 4'h7, 8'h30);
    @(posedge clk); #1;
    start = 1'b1; fmt = FMT_INSTR; data_in = 15'h2468; op_in = 4'h7; base_addr = 8'h30;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_data", mem_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_nwr", nwr - w0, 1);
    expq.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_nwr", nwr - w0, 1);
    run(FMT_WORD, 15'h7FFF, 4'h0, 8'h80, 3, 0, 0, 3);

    for (int i = 0; i < 4; i++) begin
      logic [1:0] f;
      f = 2'($urandom_range(0, 2));
      run(f, 15'($urandom), 4'($urandom), 8'($urandom), nbytes(f) + 1, 0, 0, nbytes(f) + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
